// File: rtl/uart_cfg_pkg.sv
// Shared constants, state encodings and parity helper for the parametrised UART.
package uart_cfg_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Parity bit for a data word zero-padded to 9 bits; padding never changes the XOR.
  function automatic logic parity_bit(input logic [8:0] d, input int mode);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_cfg_if.sv
// Host-side handshake bundle of uart_cfg: TX load path and RX unload/status path.
interface uart_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 ld_tx_data;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_enable;
  logic                 tx_empty;
  logic                 uld_rx_data;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_enable;
  logic                 rx_empty;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_over_run;

  modport master (
    output ld_tx_data, tx_data, tx_enable, uld_rx_data, rx_enable,
    input  tx_empty, rx_data, rx_empty, rx_frame_err, rx_parity_err, rx_over_run
  );

  modport slave (
    input  ld_tx_data, tx_data, tx_enable, uld_rx_data, rx_enable,
    output tx_empty, rx_data, rx_empty, rx_frame_err, rx_parity_err, rx_over_run
  );
endinterface

// File: rtl/uart_cfg_rx.sv
// UART receiver: 2-flop synchroniser, 16x oversampling FSM with false-start
// rejection, holding register and sticky frame/parity/overrun flags.
module uart_cfg_rx
  import uart_cfg_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int CLK_DIV   = 27
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_in,
  input  logic                 rx_enable,
  input  logic                 uld_rx_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_over_run
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);

  logic                 rx_s1, rx_s2;
  rx_state_e            rx_st;
  logic [DIV_W-1:0]     rx_div;
  logic [OS_W-1:0]      rx_os;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_par;
  logic                 mid, stop_hit, ferr, perr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_in;
      rx_s2 <= rx_s1;
    end
  end

  // Sample point: last divider tick of oversample count 8 within each bit window.
  assign mid      = (rx_div == DIV_LAST) && (rx_os == OS_MID);
  assign stop_hit = rx_enable && (rx_st == RX_STOP) && mid;
  assign ferr     = ~rx_s2;
  assign perr     = (PARITY != PAR_NONE) && (rx_par != parity_bit(9'(rx_sh), PARITY));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_st  <= RX_IDLE;
      rx_div <= '0;
      rx_os  <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
      rx_par <= 1'b0;
    end else if (!rx_enable) begin
      rx_st <= RX_IDLE;
    end else begin
      if (rx_st != RX_IDLE) begin
        if (rx_div == DIV_LAST) begin
          rx_div <= '0;
          rx_os  <= rx_os + 1'b1;
        end else begin
          rx_div <= rx_div + 1'b1;
        end
      end
      case (rx_st)
        RX_IDLE: if (!rx_s2) begin
          rx_st  <= RX_START;
          rx_div <= '0;
          rx_os  <= '0;
        end
        RX_START: if (mid) begin
          rx_st  <= rx_s2 ? RX_IDLE : RX_DATA;
          rx_bit <= '0;
        end
        RX_DATA: if (mid) begin
          rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
          if (rx_bit == 4'(DATA_BITS - 1))
            rx_st <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          else
            rx_bit <= rx_bit + 1'b1;
        end
        RX_PARITY: if (mid) begin
          rx_par <= rx_s2;
          rx_st  <= RX_STOP;
        end
        RX_STOP: if (mid) rx_st <= RX_IDLE;
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // An unload in the same cycle as a completed frame makes room for it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data       <= '0;
      rx_empty      <= 1'b1;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_over_run   <= 1'b0;
    end else if (stop_hit && (rx_empty || uld_rx_data)) begin
      rx_data       <= rx_sh;
      rx_empty      <= 1'b0;
      rx_frame_err  <= ferr | (rx_frame_err & ~uld_rx_data);
      rx_parity_err <= perr | (rx_parity_err & ~uld_rx_data);
      rx_over_run   <= rx_over_run & ~uld_rx_data;
    end else if (stop_hit) begin
      rx_over_run <= 1'b1;
    end else if (uld_rx_data) begin
      rx_empty      <= 1'b1;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_over_run   <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_cfg.sv
// Parametrised single-clock UART: transmitter FSM here, receiver in uart_cfg_rx.
module uart_cfg
  import uart_cfg_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int CLK_DIV   = 27
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_cfg_if.slave host,
  output logic     tx_out,
  input  logic     rx_in
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

  tx_state_e            tx_st;
  logic [DIV_W-1:0]     tx_div;
  logic [OS_W-1:0]      tx_os;
  logic [3:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic                 tx_out_q, tx_empty_q;
  logic                 tx_bit_end;

  assign tx_bit_end    = (tx_div == DIV_LAST) && (tx_os == OS_LAST);
  assign tx_out        = tx_out_q;
  assign host.tx_empty = tx_empty_q;

  // tx_out is registered one bit ahead: each bit-end edge loads the next line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_st      <= TX_IDLE;
      tx_div     <= '0;
      tx_os      <= '0;
      tx_bit     <= '0;
      tx_sh      <= '0;
      tx_par     <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_empty_q <= 1'b1;
    end else begin
      if (tx_st != TX_IDLE) begin
        if (tx_div == DIV_LAST) begin
          tx_div <= '0;
          tx_os  <= tx_os + 1'b1;
        end else begin
          tx_div <= tx_div + 1'b1;
        end
      end
      case (tx_st)
        TX_IDLE: if (host.ld_tx_data && host.tx_enable) begin
          tx_st      <= TX_START;
          tx_sh      <= host.tx_data;
          tx_par     <= parity_bit(9'(host.tx_data), PARITY);
          tx_div     <= '0;
          tx_os      <= '0;
          tx_bit     <= '0;
          tx_out_q   <= 1'b0;
          tx_empty_q <= 1'b0;
        end
        TX_START: if (tx_bit_end) begin
          tx_st    <= TX_DATA;
          tx_out_q <= tx_sh[0];
          tx_sh    <= tx_sh >> 1;
        end
        TX_DATA: if (tx_bit_end) begin
          if (tx_bit == 4'(DATA_BITS - 1)) begin
            tx_bit <= '0;
            if (PARITY != PAR_NONE) begin
              tx_st    <= TX_PARITY;
              tx_out_q <= tx_par;
            end else begin
              tx_st    <= TX_STOP;
              tx_out_q <= 1'b1;
            end
          end else begin
            tx_bit   <= tx_bit + 1'b1;
            tx_out_q <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
          end
        end
        TX_PARITY: if (tx_bit_end) begin
          tx_st    <= TX_STOP;
          tx_out_q <= 1'b1;
        end
        TX_STOP: if (tx_bit_end) begin
          if (tx_bit == 4'(STOP_BITS - 1)) begin
            tx_st      <= TX_IDLE;
            tx_bit     <= '0;
            tx_empty_q <= 1'b1;
          end else begin
            tx_bit <= tx_bit + 1'b1;
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

  uart_cfg_rx #(
    .DATA_BITS (DATA_BITS),
    .PARITY    (PARITY),
    .CLK_DIV   (CLK_DIV)
  ) u_rx (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_in         (rx_in),
    .rx_enable     (host.rx_enable),
    .uld_rx_data   (host.uld_rx_data),
    .rx_data       (host.rx_data),
    .rx_empty      (host.rx_empty),
    .rx_frame_err  (host.rx_frame_err),
    .rx_parity_err (host.rx_parity_err),
    .rx_over_run   (host.rx_over_run)
  );

endmodule

// File: tb/tb_uart_cfg.sv
// Scoreboard bench for uart_cfg: an 8E1 instance (loopback or bit-banged rx_in)
// and a 7N2 loopback instance, both at CLK_DIV=4.
module tb_uart_cfg;
  import uart_cfg_pkg::*;

  localparam int CD = 4;
  localparam int BT = 16 * CD;

  typedef struct packed {
    logic       empty;
    logic [8:0] data;
    logic       fe;
    logic       pe;
    logic       ov;
  } rxv_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic tx0, tx1, rx0;
  logic lb0 = 1'b1;
  logic bb0 = 1'b1;
  int   checks = 0;
  int   failures = 0;
  rxv_t q0[$];
  rxv_t q1[$];

  always #5 clk = ~clk;
  assign rx0 = lb0 ? tx0 : bb0;

  uart_cfg_if #(.DATA_BITS(8)) h0();
  uart_cfg_if #(.DATA_BITS(7)) h1();

  uart_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLK_DIV(CD)) u0 (
    .clk(clk), .reset_n(reset_n), .host(h0), .tx_out(tx0), .rx_in(rx0));
  uart_cfg #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .CLK_DIV(CD)) u1 (
    .clk(clk), .reset_n(reset_n), .host(h1), .tx_out(tx1), .rx_in(tx1));

  function automatic rxv_t mk(input logic e, input logic [8:0] d,
                              input logic fe, input logic pe, input logic ov);
    rxv_t r;
    r.empty = e; r.data = d; r.fe = fe; r.pe = pe; r.ov = ov;
    return r;
  endfunction

  function automatic rxv_t obs(input int w);
    rxv_t r;
    if (w == 0) r = mk(h0.rx_empty, 9'(h0.rx_data), h0.rx_frame_err, h0.rx_parity_err, h0.rx_over_run);
    else        r = mk(h1.rx_empty, 9'(h1.rx_data), h1.rx_frame_err, h1.rx_parity_err, h1.rx_over_run);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out", nm);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns #1 after the edge that accepted the load.
  task automatic load(input int w, input logic [8:0] d);
    int t;
    t = 0;
    while (((w == 0) ? !h0.tx_empty : !h1.tx_empty) && t < 3000) begin idle(1); t++; end
    if (t >= 3000) tmo("load_wait");
    if (w == 0) begin h0.tx_data = d[7:0]; h0.ld_tx_data = 1'b1; end
    else        begin h1.tx_data = d[6:0]; h1.ld_tx_data = 1'b1; end
    idle(1);
    if (w == 0) h0.ld_tx_data = 1'b0;
    else        h1.ld_tx_data = 1'b0;
  endtask

  task automatic busy_len(input int w, output int n);
    n = 0;
    while (((w == 0) ? !h0.tx_empty : !h1.tx_empty) && n < 3000) begin n++; idle(1); end
  endtask

  task automatic wait_full(input int w);
    int t;
    t = 0;
    while (((w == 0) ? h0.rx_empty : h1.rx_empty) && t < 3000) begin idle(1); t++; end
    if (t >= 3000) tmo("rx_wait");
  endtask

  task automatic uld(input int w);
    if (w == 0) h0.uld_rx_data = 1'b1;
    else        h1.uld_rx_data = 1'b1;
    idle(1);
    if (w == 0) h0.uld_rx_data = 1'b0;
    else        h1.uld_rx_data = 1'b0;
  endtask

  task automatic uld_chk(input int w, input string nm);
    rxv_t r;
    uld(w);
    r = obs(w);
    chk(nm, {r.empty, r.fe, r.pe, r.ov}, 4'b1000);
  endtask

  // 8E1 frame driven straight onto u0's rx_in; a bad stop bit is held low just past its sample point.
  task automatic bb_frame(input logic [7:0] d, input logic flip_par, input logic stop_bad);
    bb0 = 1'b0; idle(BT);
    for (int i = 0; i < 8; i++) begin bb0 = d[i]; idle(BT); end
    bb0 = (^d) ^ flip_par; idle(BT);
    if (stop_bad) begin bb0 = 1'b0; idle(40); bb0 = 1'b1; idle(BT - 40); end
    else begin bb0 = 1'b1; idle(BT); end
    idle(BT);
  endtask

  task automatic monitor(input int w);
    rxv_t cur, prev, exp;
    @(posedge reset_n);
    @(negedge clk);
    prev = obs(w);
    forever begin
      @(negedge clk);
      cur = obs(w);
      if (!reset_n) prev = cur;
      else if (cur !== prev) begin
        if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
          checks++;
          failures++;
          $display("FAIL rx%0d_unexpected got=%h", w, cur);
        end else begin
          if (w == 0) exp = q0.pop_front();
          else        exp = q1.pop_front();
          chk($sformatf("rx%0d_word", w), 16'(cur), 16'(exp));
        end
        prev = cur;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, na, nb;
    h0.ld_tx_data = 0; h0.tx_data = '0; h0.tx_enable = 1; h0.uld_rx_data = 0; h0.rx_enable = 1;
    h1.ld_tx_data = 0; h1.tx_data = '0; h1.tx_enable = 1; h1.uld_rx_data = 0; h1.rx_enable = 1;
    #2 reset_n = 1'b0;
    #21;
    chk("rst_tx0", {tx0, h0.tx_empty}, 2'b11);
    chk("rst_rx0", 16'(obs(0)), 16'(mk(1, 0, 0, 0, 0)));
    chk("rst_tx1", {tx1, h1.tx_empty}, 2'b11);
    chk("rst_rx1", 16'(obs(1)), 16'(mk(1, 0, 0, 0, 0)));
    @(posedge clk); #1 reset_n = 1'b1;
    idle(4);

    // load with tx_enable low is ignored
    h0.tx_enable = 0; h0.tx_data = 8'hFF; h0.ld_tx_data = 1; idle(1);
    h0.ld_tx_data = 0; idle(2);
    chk("txen_off", {tx0, h0.tx_empty}, 2'b11);
    h0.tx_enable = 1;

    // 8E1 loopback 0x41
    q0.push_back(mk(0, 9'h41, 0, 0, 0));
    load(0, 9'h41);
    chk("tx_start_bit", {tx0, h0.tx_empty}, 2'b00);
    busy_len(0, n);
    chk("tx_busy_8e1", 16'(n), 16'd704);
    idle(BT);
    q0.push_back(mk(1, 9'h41, 0, 0, 0));
    uld_chk(0, "uld_41");

    // bit-banged error frames
    lb0 = 1'b0;
    q0.push_back(mk(0, 9'h3C, 1, 0, 0));
    bb_frame(8'h3C, 1'b0, 1'b1);
    q0.push_back(mk(1, 9'h3C, 0, 0, 0));
    uld_chk(0, "uld_ferr");
    q0.push_back(mk(0, 9'hA5, 0, 1, 0));
    bb_frame(8'hA5, 1'b1, 1'b0);
    q0.push_back(mk(1, 9'hA5, 0, 0, 0));
    uld_chk(0, "uld_perr");
    q0.push_back(mk(0, 9'h0F, 1, 1, 0));
    bb_frame(8'h0F, 1'b1, 1'b1);
    q0.push_back(mk(1, 9'h0F, 0, 0, 0));
    uld_chk(0, "uld_both");

    // short low glitch is a false start
    bb0 = 1'b0; idle(4 * CD); bb0 = 1'b1; idle(3 * BT);
    chk("glitch_empty", h0.rx_empty, 1'b1);
    lb0 = 1'b1;

    // overrun: second frame with no unload keeps the first word
    q0.push_back(mk(0, 9'h55, 0, 0, 0));
    q0.push_back(mk(0, 9'h55, 0, 0, 1));
    load(0, 9'h55);
    load(0, 9'hAA);
    busy_len(0, n);
    idle(BT);
    q0.push_back(mk(1, 9'h55, 0, 0, 0));
    uld_chk(0, "uld_ovr");

    // unload coincident with second STOP sample (edge n+675 after accept)
    q0.push_back(mk(0, 9'h55, 0, 0, 0));
    q0.push_back(mk(0, 9'hAA, 0, 0, 0));
    load(0, 9'h55);
    load(0, 9'hAA);
    idle(674);
    uld(0);
    chk("coinc_state", {h0.rx_empty, h0.rx_over_run, h0.rx_data}, {2'b00, 8'hAA});
    busy_len(0, n);
    idle(BT);
    q0.push_back(mk(1, 9'hAA, 0, 0, 0));
    uld_chk(0, "uld_coinc");

    // 7N2 back-to-back 0x7F, 0x00
    q1.push_back(mk(0, 9'h7F, 0, 0, 0));
    q1.push_back(mk(1, 9'h7F, 0, 0, 0));
    q1.push_back(mk(0, 9'h00, 0, 0, 0));
    q1.push_back(mk(1, 9'h00, 0, 0, 0));
    fork
      begin
        load(1, 9'h7F);
        busy_len(1, na);
        load(1, 9'h00);
        busy_len(1, nb);
      end
      begin
        wait_full(1); uld(1);
        wait_full(1); uld(1);
      end
    join
    chk("tx_busy_7n2_a", 16'(na), 16'd640);
    chk("tx_busy_7n2_b", 16'(nb), 16'd640);
    idle(BT);

    // reset mid-data on both TX and RX
    load(0, 9'h33);
    load(1, 9'h33);
    idle(200);
    reset_n = 1'b0;
    #1;
    chk("midrst_0", {tx0, h0.tx_empty, h0.rx_empty, h0.rx_data}, {3'b111, 8'h00});
    chk("midrst_1", {tx1, h1.tx_empty, h1.rx_empty, 1'b0, h1.rx_data}, {3'b111, 8'h00});
    idle(2);
    reset_n = 1'b1;
    idle(2);
    q0.push_back(mk(0, 9'hC3, 0, 0, 0));
    q1.push_back(mk(0, 9'h2A, 0, 0, 0));
    load(0, 9'hC3);
    load(1, 9'h2A);
    wait_full(0);
    wait_full(1);
    idle(BT);

    chk("sb0_drained", 16'(q0.size()), 16'd0);
    chk("sb1_drained", 16'(q1.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cfg.md
# uart_cfg

Parametrised single-clock UART, successor to the dual-clock fixed-format `uart`. Data width, parity, stop-bit count and baud divisor are compile-time parameters. The receiver oversamples 16× with false-start rejection and reports sticky framing, parity and overrun errors. It sits between the register/host logic and the serial pins, and keeps the `ld_tx_data` / `uld_rx_data` handshake style of `uart`.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame, legal 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal 1 or 2.
- `CLK_DIV`, default 27: clk cycles per 1/16 bit time, ≥ 2.

Ports:
- `clk` in 1: single clock for the whole block. One clock; reset is asynchronous and active-low.
- `reset_n` in 1: asynchronous, active-low reset.
- `ld_tx_data` in 1: load `tx_data` into the TX holding register.
- `tx_data` in DATA_BITS: byte to transmit, LSB first.
- `tx_enable` in 1: permits a new frame to start.
- `tx_out` out 1: serial output, idles 1.
- `tx_empty` out 1: TX idle and able to accept a load.
- `uld_rx_data` in 1: host has consumed `rx_data`; clears flags.
- `rx_data` out DATA_BITS: last received word.
- `rx_enable` in 1: receiver enable.
- `rx_in` in 1: serial input, asynchronous.
- `rx_empty` out 1: no unread word.
- `rx_frame_err` out 1: sticky; stop bit sampled 0.
- `rx_parity_err` out 1: sticky; parity mismatch.
- `rx_over_run` out 1: sticky; frame completed while `rx_empty` = 0.

## Operation
- Reset values: `tx_out`=1, `tx_empty`=1, `rx_empty`=1, `rx_data`=0, all error flags 0, both FSMs IDLE.
- TX FSM: IDLE → START → DATA → PARITY (skipped if `PARITY`=0) → STOP → IDLE.
- TX load rule: `ld_tx_data` with `tx_empty`=1 and `tx_enable`=1 latches `tx_data` and starts the frame.
- A load while `tx_empty`=0 or `tx_enable`=0 is ignored.
- Deasserting `tx_enable` mid-frame does not abort; the current frame completes.
- Parity covers the DATA_BITS data bits. Odd: data+parity has an odd number of 1s. Even: an even number.
- RX: `rx_in` passes a 2-flop synchroniser. RX FSM: IDLE → START → DATA → PARITY (skipped if none) → STOP → IDLE.
- IDLE→START on a synchronised falling level (sampled 0).
- START samples at oversample count 8. A sample of 1 is a false start: return to IDLE with no flags.
- Each later bit is sampled at count 8 of its 16-count window.
- Only the first stop bit is checked.
- On the STOP sample with `rx_empty`=1: load `rx_data`, set `rx_empty`=0, OR frame/parity error into the sticky flags.
- On the STOP sample with `rx_empty`=0: set `rx_over_run`=1 and keep the old `rx_data`. The new word's errors are discarded.
- `uld_rx_data`: next cycle `rx_empty`=1 and all three error flags are 0.
- `uld_rx_data` in the same cycle as a STOP sample: the new word loads, `rx_empty` stays 0, no overrun, flags take the new frame's values only.
- `rx_enable`=0 forces RX to IDLE immediately, abandoning any partial frame. Flags and `rx_data` are held.
- `reset_n` low mid-frame: both FSMs return to IDLE asynchronously and all outputs take reset values.

## Timing
- Bit time = 16·CLK_DIV cycles. TX and RX each have a private divider, restarted at frame start.
- TX: with `ld_tx_data` accepted at edge n, `tx_out`=0 and `tx_empty`=0 from n+1.
- TX frame length F = 16·CLK_DIV·(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles.
- `tx_empty` returns to 1 the cycle after the last stop bit ends. Back-to-back loads are therefore allowed with no extra idle.
- RX: the STOP sample falls 2 (sync) + 8·CLK_DIV + 16·CLK_DIV·(DATA_BITS+(PARITY≠0)+1) cycles after `rx_in` falls, ±1 cycle.
- `rx_empty` falls and the flags update on the cycle after the STOP sample.
- RX returns to IDLE at the STOP sample. This tolerates up to a half-bit of sender clock skew.

## Structure
- Package `uart_cfg_pkg` holds:
  - parity encoding constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - the TX and RX state enumerations;
  - the `OVERSAMPLE` = 16 constant.
- Sub-module `uart_cfg_rx` holds the synchroniser, RX divider, RX FSM and the flag/holding logic.
- TX stays in the top level.

## Test plan
- Loopback (`tx_out`→`rx_in`), DATA_BITS=8, PARITY=2, STOP_BITS=1, CLK_DIV=4: send 0x41 → `tx_empty` low exactly 704 cycles; `rx_data`=0x41, `rx_empty`=0, no flags.
- Same config: stop bit forced 0 → `rx_frame_err`=1 with `rx_data` loaded. Flipping the parity bit → `rx_parity_err`=1. `uld_rx_data` clears both next cycle.
- Two loopback frames 0x55 then 0xAA without `uld_rx_data` → `rx_data`=0x55, `rx_over_run`=1. Also: `uld_rx_data` coincident with the second STOP sample → `rx_data`=0xAA, `rx_over_run`=0.
- `rx_in` low pulse of 4·CLK_DIV cycles → no state change, `rx_empty`=1, no flags.
- DATA_BITS=7, PARITY=0, STOP_BITS=2: send 0x7F then 0x00 back-to-back (second load the cycle `tx_empty` rises) → both received in order; each frame 10 bit times.
- `reset_n` pulsed low mid-TX-data and mid-RX-data → `tx_out`=1, `tx_empty`=1, `rx_empty`=1 immediately; the next frame is received correctly.
